// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types
// Description : Shared branch-predictor types and counter encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

   typedef enum logic [0:0] {
      BP_CLEAR = 1'b0,
      BP_READY = 1'b1
   } bp_seq_state_t;

   localparam logic [1:0] BP_CNT_STRONG_T = 2'b11;
   localparam logic [1:0] BP_CNT_WEAK_T   = 2'b10;
   localparam logic [1:0] BP_CNT_WEAK_NT  = 2'b01;

endpackage

`default_nettype wire

// File: rtl/sat_counter_update.sv
// ============================================================================
// Module      : sat_counter_update
// Description : Next 2-bit prediction counter for a resolved branch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter_update
   import rv32i_types::*;
(
   input  logic [1:0] counter,
   input  logic       taken,
   input  logic       hit,
   input  logic       jump,
   output logic [1:0] next_counter
);

   // A BTB miss has no trustworthy history, so it seeds a weak state instead.
   always_comb begin
      next_counter = counter;
      if (jump) begin
         next_counter = BP_CNT_STRONG_T;
      end else if (!hit) begin
         next_counter = taken ? BP_CNT_WEAK_T : BP_CNT_WEAK_NT;
      end else if (taken) begin
         next_counter = (counter == 2'b11) ? counter : counter + 2'd1;
      end else begin
         next_counter = (counter == 2'b00) ? counter : counter - 2'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bp_update_sequencer.sv
// ============================================================================
// Module      : bp_update_sequencer
// Description : Sequences clear sweeps, MEM-stage counter updates and flush
//               pulses onto the predictor tables' single write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_update_sequencer
   import rv32i_types::*;
#(
   parameter int         s_index      = 10,
   parameter logic [1:0] init_counter = 2'b01
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_valid,
   input  logic               mem_stall,
   input  logic               mem_is_branch,
   input  logic               mem_is_jump,
   input  logic               mem_BTB_hit,
   input  logic [1:0]         mem_predicted_branch_outcome,
   input  logic               mem_actual_branch_outcome,
   input  logic               mem_misprediction,
   input  logic [31:0]        mem_pc_out,
   input  logic               inval_req,
   output logic               wr_en,
   output logic [s_index-1:0] wr_index,
   output logic [1:0]         wr_counter,
   output logic               wr_clear,
   output logic               bp_ready,
   output logic               flush_pipeline
);

   localparam logic [s_index-1:0] c_idx_one  = s_index'(1);
   localparam logic [s_index-1:0] c_idx_last = {s_index{1'b1}};

   bp_seq_state_t      r_state, w_state_nxt;
   logic [s_index-1:0] r_sweep_idx, w_idx_nxt;
   logic               r_done, w_done_nxt;
   logic               w_wr_en_nxt, w_wr_clear_nxt, w_bp_ready_nxt, w_flush_nxt;
   logic [s_index-1:0] w_wr_index_nxt;
   logic [1:0]         w_wr_counter_nxt;
   logic [1:0]         w_upd_counter;
   logic               w_event;
   logic               w_unused_pc_bits;

   assign w_unused_pc_bits = ^{mem_pc_out[31:s_index+2], mem_pc_out[1:0]};

   // done keeps a stalled instruction from being seen again while it sits in MEM
   assign w_event = mem_valid & mem_is_branch & ~r_done;

   sat_counter_update u_sat (
      .counter      (mem_predicted_branch_outcome),
      .taken        (mem_actual_branch_outcome),
      .hit          (mem_BTB_hit),
      .jump         (mem_is_jump),
      .next_counter (w_upd_counter)
   );

   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_sweep_idx;
      w_done_nxt       = r_done;
      w_wr_en_nxt      = 1'b0;
      w_wr_index_nxt   = '0;
      w_wr_counter_nxt = 2'b00;
      w_wr_clear_nxt   = 1'b0;
      w_bp_ready_nxt   = 1'b0;
      w_flush_nxt      = w_event & mem_misprediction;

      if (inval_req) begin
         // Entry 0 is written immediately, so the sweep resumes at 1.
         w_state_nxt      = BP_CLEAR;
         w_idx_nxt        = c_idx_one;
         w_wr_en_nxt      = 1'b1;
         w_wr_clear_nxt   = 1'b1;
         w_wr_counter_nxt = init_counter;
      end else begin
         case (r_state)
            BP_CLEAR: begin
               w_wr_en_nxt      = 1'b1;
               w_wr_clear_nxt   = 1'b1;
               w_wr_index_nxt   = r_sweep_idx;
               w_wr_counter_nxt = init_counter;
               w_idx_nxt        = r_sweep_idx + c_idx_one;
               if (r_sweep_idx == c_idx_last) begin
                  w_state_nxt = BP_READY;
               end
            end
            BP_READY: begin
               w_bp_ready_nxt = 1'b1;
               if (w_event) begin
                  w_wr_en_nxt      = 1'b1;
                  w_wr_index_nxt   = mem_pc_out[s_index+1:2];
                  w_wr_counter_nxt = w_upd_counter;
               end
            end
            default: begin
               w_state_nxt = BP_CLEAR;
               w_idx_nxt   = '0;
            end
         endcase
      end

      if (!mem_stall) begin
         w_done_nxt = 1'b0;
      end else if (w_event && !inval_req) begin
         w_done_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= BP_CLEAR;
         r_sweep_idx    <= '0;
         r_done         <= 1'b0;
         wr_en          <= 1'b0;
         wr_index       <= '0;
         wr_counter     <= 2'b00;
         wr_clear       <= 1'b0;
         bp_ready       <= 1'b0;
         flush_pipeline <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_sweep_idx    <= w_idx_nxt;
         r_done         <= w_done_nxt;
         wr_en          <= w_wr_en_nxt;
         wr_index       <= w_wr_index_nxt;
         wr_counter     <= w_wr_counter_nxt;
         wr_clear       <= w_wr_clear_nxt;
         bp_ready       <= w_bp_ready_nxt;
         flush_pipeline <= w_flush_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bp_update_sequencer.sv
// ============================================================================
// Module      : tb_bp_update_sequencer
// Description : Scoreboard bench for bp_update_sequencer with s_index=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_update_sequencer;

   localparam int         SI   = 3;
   localparam int         DEPTH = 1 << SI;
   localparam logic [1:0] INIT = 2'b01;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mem_valid = 0, mem_stall = 0, mem_is_branch = 0, mem_is_jump = 0;
   logic          mem_BTB_hit = 0, mem_actual_branch_outcome = 0, mem_misprediction = 0;
   logic [1:0]    mem_predicted_branch_outcome = 2'b00;
   logic [31:0]   mem_pc_out = 32'h0;
   logic          inval_req = 0;
   logic          wr_en, wr_clear, bp_ready, flush_pipeline;
   logic [SI-1:0] wr_index;
   logic [1:0]    wr_counter;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic          en;
      logic [SI-1:0] idx;
      logic [1:0]    cnt;
      logic          clr;
      logic          rdy;
      logic          fl;
   } exp_t;

   exp_t exp_q[$];

   bp_update_sequencer #(.s_index(SI), .init_counter(INIT)) dut (
      .clk                          (clk),
      .rst                          (rst),
      .mem_valid                    (mem_valid),
      .mem_stall                    (mem_stall),
      .mem_is_branch                (mem_is_branch),
      .mem_is_jump                  (mem_is_jump),
      .mem_BTB_hit                  (mem_BTB_hit),
      .mem_predicted_branch_outcome (mem_predicted_branch_outcome),
      .mem_actual_branch_outcome    (mem_actual_branch_outcome),
      .mem_misprediction            (mem_misprediction),
      .mem_pc_out                   (mem_pc_out),
      .inval_req                    (inval_req),
      .wr_en                        (wr_en),
      .wr_index                     (wr_index),
      .wr_counter                   (wr_counter),
      .wr_clear                     (wr_clear),
      .bp_ready                     (bp_ready),
      .flush_pipeline               (flush_pipeline)
   );

   always #5 clk = ~clk;

   // Reference counter rule expressed as integer arithmetic.
   function automatic logic [1:0] ref_next(int c, bit tk, bit hit, bit jmp);
      int n;
      if (jmp)       n = 3;
      else if (!hit) n = tk ? 2 : 1;
      else if (tk)   n = (c + 1 > 3) ? 3 : c + 1;
      else           n = (c - 1 < 0) ? 0 : c - 1;
      return n[1:0];
   endfunction

   // Behavioural model: a sweep position counter plus a "seen while stalled" bit.
   int m_sweep    = 0;
   bit m_clearing = 1'b1;
   bit m_seen     = 1'b0;

   always @(posedge clk) begin
      exp_t e;
      bit   ev;
      e = '0;
      if (!rst) begin
         m_clearing = 1'b1;
         m_sweep    = 0;
         m_seen     = 1'b0;
      end else begin
         ev   = mem_valid && mem_is_branch && !m_seen;
         e.fl = ev && mem_misprediction;
         if (inval_req) begin
            e.en = 1; e.clr = 1; e.idx = '0; e.cnt = INIT;
            m_clearing = 1'b1;
            m_sweep    = 1;
         end else if (m_clearing) begin
            e.en = 1; e.clr = 1; e.idx = m_sweep[SI-1:0]; e.cnt = INIT;
            m_sweep = m_sweep + 1;
            if (m_sweep == DEPTH) m_clearing = 1'b0;
         end else begin
            e.rdy = 1;
            if (ev) begin
               e.en  = 1;
               e.idx = mem_pc_out[SI+1:2];
               e.cnt = ref_next(int'(mem_predicted_branch_outcome),
                                mem_actual_branch_outcome, mem_BTB_hit, mem_is_jump);
            end
         end
         if (!mem_stall)                m_seen = 1'b0;
         else if (ev && !inval_req)     m_seen = 1'b1;
      end
      exp_q.push_back(e);
   end

   // Monitor: one expected output vector per clock, checked off the edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty t=%0t got none required one entry", $time);
      end else begin
         e = exp_q.pop_front();
         if (wr_en !== e.en || wr_clear !== e.clr || bp_ready !== e.rdy ||
             flush_pipeline !== e.fl ||
             (e.en && (wr_index !== e.idx || wr_counter !== e.cnt))) begin
            bad++;
            $display("FAIL outputs t=%0t got en=%b idx=%0d cnt=%0d clr=%b rdy=%b fl=%b required en=%b idx=%0d cnt=%0d clr=%b rdy=%b fl=%b",
                     $time, wr_en, wr_index, wr_counter, wr_clear, bp_ready, flush_pipeline,
                     e.en, e.idx, e.cnt, e.clr, e.rdy, e.fl);
         end
      end
   end

   task automatic drive(bit v, bit st, bit br, bit jmp, bit hit, logic [1:0] pred,
                        bit tk, bit mis, logic [31:0] pc, bit inv);
      @(negedge clk);
      mem_valid = v; mem_stall = st; mem_is_branch = br; mem_is_jump = jmp;
      mem_BTB_hit = hit; mem_predicted_branch_outcome = pred;
      mem_actual_branch_outcome = tk; mem_misprediction = mis;
      mem_pc_out = pc; inval_req = inv;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 0);
   endtask

   initial begin
      idle(3);
      @(negedge clk); rst = 1'b1;
      idle(DEPTH + 3);

      // Saturation and ordinary BTB-hit updates.
      drive(1, 0, 1, 0, 1, 2'd3, 1, 0, 32'h14, 0);
      drive(1, 0, 1, 0, 1, 2'd0, 0, 0, 32'h18, 0);
      drive(1, 0, 1, 0, 1, 2'd1, 1, 0, 32'h1c, 0);
      idle(2);

      // Stalled branch held for four cycles, then released and followed by a new one.
      for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 1, 2'd2, 1, 0, 32'h40, 0);
      drive(1, 0, 1, 0, 1, 2'd2, 1, 0, 32'h40, 0);
      drive(1, 0, 1, 0, 1, 2'd2, 0, 0, 32'h44, 0);
      idle(2);

      // BTB-miss taken misprediction, then a jump.
      drive(1, 0, 1, 0, 0, 2'd0, 1, 1, 32'h88, 0);
      drive(1, 0, 1, 1, 0, 2'd0, 1, 0, 32'h8c, 0);
      idle(2);

      // Invalidate coinciding with an accepted mispredicted branch.
      drive(1, 0, 1, 0, 1, 2'd1, 1, 1, 32'h30, 1);
      idle(DEPTH + 3);

      // Asynchronous reset in the middle of a sweep.
      drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 1);
      idle(4);
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (wr_en !== 1'b0 || wr_clear !== 1'b0 || bp_ready !== 1'b0 ||
          flush_pipeline !== 1'b0 || wr_index !== '0 || wr_counter !== 2'b00) begin
         bad++;
         $display("FAIL async_reset got en=%b idx=%0d cnt=%0d clr=%b rdy=%b fl=%b required all zero",
                  wr_en, wr_index, wr_counter, wr_clear, bp_ready, flush_pipeline);
      end
      idle(1);
      @(negedge clk); rst = 1'b1;
      idle(DEPTH + 3);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
               $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
               $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
               $urandom, $urandom_range(0, 99) < 2);
      end
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bp_update_sequencer.md
# bp_update_sequencer

Owns the single write port of the branch predictor's prediction tables: the local counters, the tournament selector and the tag-valid clear. It sequences three activities on that port: a table-clear sweep after reset or an invalidate request, one-shot MEM-stage counter updates that stay safe under pipeline stalls, and the registered pipeline-flush pulse on a misprediction. It sits beside branch_prediction_datapath, between the MEM-stage pipeline register and the predictor arrays.

## Interface
Parameters:
- s_index, 10, index width of every predictor table; table depth is 2**s_index.
- init_counter, 2'b01, counter value written by the clear sweep (weakly not-taken).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_stall  in  1  pipeline held this cycle; the MEM instruction does not advance.
- mem_is_branch  in  1  MEM instruction is a conditional branch, jal or jalr.
- mem_is_jump  in  1  MEM instruction is jal or jalr.
- mem_BTB_hit  in  1  the MEM instruction hit in the BTB at fetch.
- mem_predicted_branch_outcome  in  2  counter value read at fetch.
- mem_actual_branch_outcome  in  1  resolved direction; 1 = taken.
- mem_misprediction  in  1  misprediction flag from the datapath.
- mem_pc_out  in  32  MEM-stage PC.
- inval_req  in  1  request to invalidate the whole predictor (fence.i).
- wr_en  out  1  write strobe for the tables.
- wr_index  out  s_index  write index.
- wr_counter  out  2  counter value to write.
- wr_clear  out  1  this write is a clear; tag/valid entries are invalidated.
- bp_ready  out  1  tables valid; while 0 the frontend must treat every prediction as not-taken.
- flush_pipeline  out  1  one-cycle pulse; squash IF/ID/EX.

## Operation
- States: CLEAR, READY.
- Reset enters CLEAR with the sweep index at 0.
- **CLEAR state**
  - Each cycle writes wr_en=1, wr_clear=1, wr_index=sweep index, wr_counter=init_counter, then increments the index.
  - After index 2**s_index-1 has been written, the FSM moves to READY.
  - MEM events are not written to the tables; flush_pipeline is still generated for them.
- **READY state**
  - An accept occurs when mem_valid & mem_is_branch & ~done are all true.
  - done is a sticky flag. It sets on an accept while mem_stall=1 and clears on any cycle with mem_stall=0. A stalled instruction therefore updates exactly once.
- **Next counter on accept**
  - Jump: 2'b11.
  - BTB miss: 2'b10 if taken, 2'b01 if not taken.
  - BTB hit: saturating update; +1 capped at 3 if taken, −1 floored at 0 if not taken.
- **Write and flush**
  - wr_index = mem_pc_out[s_index+1:2], wr_clear=0.
  - flush_pipeline is pulsed when the accept carries mem_misprediction=1.
- **inval_req** (level, sampled each cycle, highest priority)
  - Next state is CLEAR with the index reset to 0.
  - A same-cycle accept is dropped: no write and no done set. Its flush still occurs.
  - Asserted during CLEAR, it restarts the sweep from 0.
- Reset asserted mid-sweep or mid-update restarts everything.

## Timing
- All outputs are registered.
- Reset values: wr_en=0, wr_index=0, wr_counter=0, wr_clear=0, bp_ready=0, flush_pipeline=0.
- Sweep:
  - The first clock edge after rst rises presents index 0.
  - Index k is presented on cycle k+1.
  - wr_en falls and bp_ready rises together on cycle 2**s_index+1.
- Update latency: an accept in cycle t drives wr_* in cycle t+1, for one cycle only.
- Flush latency: flush_pipeline is high in cycle t+1 for exactly one cycle.
- Back-to-back accepts in consecutive cycles produce back-to-back writes.
- inval_req in cycle t: bp_ready is low from t+1, and the first clear write is presented at t+1.

## Structure
- In rv32i_types:
  - bp_seq_state_t enum {BP_CLEAR, BP_READY}.
  - Constants BP_CNT_STRONG_T=2'b11, BP_CNT_WEAK_T=2'b10, BP_CNT_WEAK_NT=2'b01.
- One combinational sub-module, sat_counter_update: inputs counter, taken, hit, jump; output the next counter.
- FSM, sweep counter, done flag and output registers live in the top module.

## Test plan
All scenarios use s_index=3.
- **Reset sweep:** release rst → wr_en=1 with wr_index 0..7 on cycles 1..8, wr_clear=1, wr_counter=01; bp_ready=1 on cycle 9.
- **Saturation:** in READY, a BTB-hit taken branch with counter 3 at pc 0x14 → wr_index=5, wr_counter=3; a not-taken with counter 0 → wr_counter=0; a taken with counter 1 → 2.
- **Stall dedupe:** an accepted branch held 4 cycles with mem_stall=1 → exactly one wr_en pulse; after stall release, the next branch is accepted normally.
- **Misprediction:** a BTB-miss taken branch with mem_misprediction=1 → next cycle flush_pipeline=1 for one cycle, wr_counter=10.
- **Invalidate:** inval_req in the same cycle as an accept → no update write, flush still pulses, sweep 0..7 follows, bp_ready low for 8 cycles.
- **Async reset:** assert rst mid-sweep at index 4 → outputs 0 immediately; after release, the sweep restarts at 0.
